// File: rtl/sweep_averager.sv
// Coherent sweep averager: sums N sweeps of ADC samples per BRAM address into an
// internal accumulator RAM. Define SWEEP_AVERAGER_SAT_EN for saturating sums (default wraps).
module sweep_averager #(
    parameter int unsigned BRAM_WIDTH  = 13,
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned N_AVG_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   arm,
    input  logic [N_AVG_WIDTH-1:0] n_avg,
    input  logic                   start,
    input  logic                   wen,
    input  logic [BRAM_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic [BRAM_WIDTH-1:0]  rd_addr,
    output logic [ACC_WIDTH-1:0]   rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [N_AVG_WIDTH-1:0] sweep_count
);

    localparam int unsigned DEPTH = 1 << BRAM_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [N_AVG_WIDTH-1:0] n_lat;
    logic [N_AVG_WIDTH-1:0] n_lat_nxt;
    logic [N_AVG_WIDTH-1:0] count_nxt;
    logic                   win_open;
    logic                   win_nxt;
    logic                   prev_sample;
    logic                   accept;
    logic                   flush;
    logic                   busy_nxt;
    logic                   done_nxt;

    // read-modify-write pipeline registers
    logic                         s0_valid;
    logic                         s0_first;
    logic [BRAM_WIDTH-1:0]        s0_addr;
    logic signed [DATA_WIDTH-1:0] s0_din;
    logic                         s1_valid;
    logic                         s1_first;
    logic [BRAM_WIDTH-1:0]        s1_addr;
    logic signed [DATA_WIDTH-1:0] s1_din;

    logic [ACC_WIDTH-1:0] mem [DEPTH];
    logic [ACC_WIDTH-1:0] ram_q;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] din_ext;
    logic [ACC_WIDTH-1:0] sum_raw;
    logic [ACC_WIDTH-1:0] sum;
    logic                 mem_we;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next state, window tracking and sweep counting; arm overrides everything
    always_comb begin
        next_state = state;
        n_lat_nxt  = n_lat;
        count_nxt  = sweep_count;
        win_nxt    = win_open;
        accept     = 1'b0;
        flush      = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = S_IDLE;
            end
            S_ARMED: begin
                if (start) begin
                    next_state = S_ACCUM;
                    win_nxt    = 1'b1;
                    accept     = wen;
                end
            end
            S_ACCUM: begin
                if (win_open) begin
                    accept = wen;
                    // falling edge of wen closes the sweep
                    if (prev_sample && !wen) begin
                        win_nxt   = 1'b0;
                        count_nxt = sweep_count + N_AVG_WIDTH'(1);
                        if (count_nxt == n_lat) begin
                            next_state = S_DRAIN;
                        end
                    end
                end else if (start) begin
                    win_nxt = 1'b1;
                    accept  = wen;
                end
            end
            S_DRAIN: begin
                next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_DONE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if (arm) begin
            next_state = S_ARMED;
            n_lat_nxt  = (n_avg == '0) ? N_AVG_WIDTH'(1) : n_avg;
            count_nxt  = '0;
            win_nxt    = 1'b0;
            accept     = 1'b0;
            flush      = 1'b1;
        end

        busy_nxt = (next_state == S_ARMED) || (next_state == S_ACCUM) ||
                   (next_state == S_DRAIN);
        done_nxt = (next_state == S_DONE);
    end

    // control and pipeline registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n_lat       <= N_AVG_WIDTH'(1);
            sweep_count <= '0;
            win_open    <= 1'b0;
            prev_sample <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            s0_valid    <= 1'b0;
            s0_first    <= 1'b0;
            s0_addr     <= '0;
            s0_din      <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_addr     <= '0;
            s1_din      <= '0;
        end else begin
            n_lat       <= n_lat_nxt;
            sweep_count <= count_nxt;
            win_open    <= win_nxt;
            prev_sample <= accept;
            busy        <= busy_nxt;
            done        <= done_nxt;
            s0_valid    <= accept;
            if (accept) begin
                s0_first <= (sweep_count == '0);
                s0_addr  <= address;
                s0_din   <= din;
            end
            s1_valid <= s0_valid && !flush;
            s1_first <= s0_first;
            s1_addr  <= s0_addr;
            s1_din   <= s0_din;
        end
    end

    // first sweep of a run overwrites whatever the RAM held
    always_comb begin
        acc_base = s1_first ? '0 : ram_q;
        din_ext  = ACC_WIDTH'(s1_din);
        sum_raw  = acc_base + din_ext;
`ifdef SWEEP_AVERAGER_SAT_EN
        if ((acc_base[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
            (sum_raw[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1])) begin
            sum = acc_base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = sum_raw;
        end
`else
        sum = sum_raw;
`endif
    end

    assign mem_we = s1_valid && !flush;

    // accumulator RAM: RMW read port and write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[s1_addr] <= sum;
        end
        ram_q <= mem[s0_addr];
    end

    // software read port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sweep_averager.sv
// Self-checking bench for sweep_averager (BRAM_WIDTH=4, ACC_WIDTH=16) with a
// per-address arithmetic reference model.
module tb_sweep_averager;

    logic        clk = 1'b0;
    logic        resetn;
    logic        arm;
    logic [15:0] n_avg;
    logic        start;
    logic        wen;
    logic [3:0]  address;
    logic [13:0] din;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] sweep_count;

    int checks = 0;
    int errors = 0;

    int model [16];
    int dval  [16];
    int m_count;
    int m_n;
    bit m_active;

    int   done_rises = 0;
    logic done_q = 1'b0;
    int   rises0;

    sweep_averager #(
        .BRAM_WIDTH (4),
        .DATA_WIDTH (14),
        .ACC_WIDTH  (16),
        .N_AVG_WIDTH(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .arm        (arm),
        .n_avg      (n_avg),
        .start      (start),
        .wen        (wen),
        .address    (address),
        .din        (din),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        done_q <= done;
        if (done && !done_q) done_rises <= done_rises + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int acc_add(input int a, input int d);
        longint s;
        s = longint'(a) + longint'(d);
`ifdef SWEEP_AVERAGER_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`else
        s = s & 64'hFFFF;
        if (s >= 32768) s = s - 65536;
`endif
        return int'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input int n);
        arm   = 1'b1;
        n_avg = 16'(n);
        step();
        arm      = 1'b0;
        m_active = 1'b1;
        m_count  = 0;
        m_n      = (n == 0) ? 1 : n;
    endtask

    // mode 0: constant val, 1: din=address, 2: random, 3: dval[address]
    task automatic run_sweep(input int mode, input int val, input bit shuffle, input bit mid_start);
        int ord [16];
        int j, tmp, a, d;
        for (int i = 0; i < 16; i++) ord[i] = i;
        if (shuffle) begin
            for (int i = 15; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = ord[i];
            case (mode)
                0: d = val;
                1: d = a;
                2: d = int'($urandom_range(16383, 0)) - 8192;
                default: d = dval[a];
            endcase
            address = 4'(a);
            din     = 14'(d);
            wen     = 1'b1;
            start   = mid_start && (i == 8);
            step();
            if (m_active) model[a] = (m_count == 0) ? d : acc_add(model[a], d);
        end
        start = 1'b0;
        wen   = 1'b0;
        step();
        if (m_active) begin
            m_count++;
            if (m_count == m_n) m_active = 1'b0;
        end
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            step();
            chk($sformatf("%s[%0d]", tag, a), {16'b0, rd_data}, {16'b0, 16'(model[a])});
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        resetn = 1'b0; arm = 1'b0; n_avg = '0; start = 1'b0; wen = 1'b0;
        address = '0; din = '0; rd_addr = '0;
        m_active = 1'b0; m_count = 0; m_n = 1;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(sweep_count), 32'd0);
        chk("rst_rd", {16'b0, rd_data}, 32'd0);
        resetn = 1'b1;
        step();

        // basic single sweep with exact done latency
        do_arm(1);
        chk("armed_busy", 32'(busy), 32'd1);
        run_sweep(1, 0, 1'b0, 1'b0);
        chk("basic_done_early", 32'(done), 32'd0);
        chk("basic_count", 32'(sweep_count), 32'd1);
        step();
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        check_ram("basic");

        // start while DONE is ignored
        run_sweep(0, 100, 1'b1, 1'b0);
        chk("done_hold", 32'(done), 32'd1);
        chk("done_count", 32'(sweep_count), 32'd1);
        check_ram("done_ign");

        // build stale content 0x7777, then average -3 over it
        do_arm(4);
        run_sweep(0, 8191, 1'b1, 1'b0);
        run_sweep(0, 8191, 1'b1, 1'b0);
        run_sweep(0, 8191, 1'b1, 1'b0);
        run_sweep(0, 6010, 1'b1, 1'b0);
        wait_done("stale_done");
        rd_addr = 4'd9;
        step();
        chk("stale_7777", {16'b0, rd_data}, 32'h7777);
        do_arm(4);
        for (int k = 0; k < 4; k++) run_sweep(0, -3, 1'b1, 1'b0);
        wait_done("avg_done");
        chk("avg_count", 32'(sweep_count), 32'd4);
        rd_addr = 4'd5;
        step();
        chk("avg_m12", {16'b0, rd_data}, 32'hFFF4);
        check_ram("avg");

        // random data, random address order
        do_arm(3);
        for (int k = 0; k < 3; k++) run_sweep(2, 0, 1'b1, 1'b0);
        wait_done("rand_done");
        check_ram("rand");

        // extra start mid-window must not open another sweep
        for (int a = 0; a < 16; a++) dval[a] = int'($urandom_range(16383, 0)) - 8192;
        do_arm(2);
        run_sweep(3, 0, 1'b1, 1'b1);
        chk("mid_count1", 32'(sweep_count), 32'd1);
        run_sweep(3, 0, 1'b1, 1'b0);
        wait_done("mid_done");
        chk("mid_count2", 32'(sweep_count), 32'd2);
        check_ram("mid");

        // re-arm after 1.5 sweeps
        do_arm(2);
        run_sweep(0, 77, 1'b1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            din     = 14'd77;
            wen     = 1'b1;
            arm     = (i == 8);
            n_avg   = 16'd3;
            step();
            if (i == 8) begin
                arm = 1'b0;
                m_active = 1'b1; m_count = 0; m_n = 3;
            end
        end
        wen = 1'b0;
        step();
        chk("rearm_count", 32'(sweep_count), 32'd0);
        chk("rearm_busy", 32'(busy), 32'd1);
        chk("rearm_done", 32'(done), 32'd0);
        rises0 = done_rises;
        for (int k = 0; k < 3; k++) run_sweep(0, 5, 1'b1, 1'b0);
        wait_done("rearm_fin");
        step();
        chk("rearm_once", 32'(done_rises - rises0), 32'd1);
        check_ram("rearm");

        // arm and start together, n_avg=0 acts as 1
        arm = 1'b1; start = 1'b1; n_avg = '0;
        step();
        arm = 1'b0; start = 1'b0;
        m_active = 1'b1; m_count = 0; m_n = 1;
        chk("as_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            address = 4'(i); din = 14'd999; wen = 1'b1;
            step();
        end
        wen = 1'b0;
        step();
        chk("as_count", 32'(sweep_count), 32'd0);
        chk("as_busy2", 32'(busy), 32'd1);
        run_sweep(2, 0, 1'b1, 1'b0);
        wait_done("n0_done");
        chk("n0_count", 32'(sweep_count), 32'd1);
        check_ram("n0");

        // overflow behaviour
        do_arm(8);
        for (int k = 0; k < 8; k++) run_sweep(0, 8191, 1'b1, 1'b0);
        wait_done("ovf_done");
        rd_addr = 4'd0;
        step();
`ifdef SWEEP_AVERAGER_SAT_EN
        chk("ovf_sat", {16'b0, rd_data}, 32'h7FFF);
`else
        chk("ovf_wrap", {16'b0, rd_data}, 32'hFFF8);
`endif
        check_ram("ovf");

        // reset mid-sweep: writes for samples 3 and 4 are cancelled
        for (int a = 0; a < 16; a++) model[a] = 15;
        do_arm(3);
        for (int k = 0; k < 3; k++) run_sweep(0, 5, 1'b0, 1'b0);
        wait_done("pre_rst_done");
        do_arm(1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            address = 4'(i); din = 14'd1000; wen = 1'b1;
            step();
        end
        resetn = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_count", 32'(sweep_count), 32'd0);
        address = 4'd5;
        step();
        resetn = 1'b1;
        m_active = 1'b0;
        for (int a = 0; a < 3; a++) model[a] = 1000;
        for (int i = 6; i < 16; i++) begin
            address = 4'(i); din = 14'd1000; wen = 1'b1;
            step();
        end
        wen = 1'b0;
        step();
        chk("mrst_busy2", 32'(busy), 32'd0);
        chk("mrst_count2", 32'(sweep_count), 32'd0);
        // start in IDLE is ignored
        run_sweep(0, 2222, 1'b1, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        check_ram("mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_averager.md
# sweep_averager

Coherent sweep averager sitting directly downstream of the BRAM write-enable generator. It consumes that stage's per-sweep write strobe, sweep-start pulse and BRAM address, together with the ADC sample stream. Over a programmable number of sweeps it accumulates each address's samples into an internal dual-port accumulator RAM. Software reads the summed record through a separate read port once `done` is set.

## Interface
- `BRAM_WIDTH`, 13, address width; one sweep = 2^BRAM_WIDTH samples
- `DATA_WIDTH`, 14, signed two's-complement ADC sample width
- `ACC_WIDTH`, 32, signed accumulator width (≥ DATA_WIDTH)
- `N_AVG_WIDTH`, 16, width of the sweep-count setting

Ports:
- `clk` in 1: single clock for all logic
- `resetn` in 1: asynchronous, active-low reset
- `arm` in 1: one-cycle pulse; arms or re-arms averaging
- `n_avg` in N_AVG_WIDTH: sweeps to average; sampled on `arm`; 0 treated as 1
- `start` in 1: sweep-start pulse from the write-enable stage
- `wen` in 1: sample-valid strobe, high for one full sweep
- `address` in BRAM_WIDTH: accumulator address for the current sample
- `din` in DATA_WIDTH: ADC sample
- `rd_addr` in BRAM_WIDTH: software read address
- `rd_data` out ACC_WIDTH: accumulator content at `rd_addr`; one-cycle latency
- `busy` out 1: ARMED or ACCUM
- `done` out 1: averaging complete; held until next `arm`
- `sweep_count` out N_AVG_WIDTH: sweeps fully accumulated in the current run

## Operation
- Reset values: `busy`=0, `done`=0, `sweep_count`=0, `rd_data`=0. State goes to IDLE. RAM contents are not cleared.
- States:
  - IDLE: on `arm`, latch `n_avg` and go to ARMED.
  - ARMED: on `start`, go to ACCUM with sweep index 0.
  - ACCUM: on each `start`, open a sweep window. While the window is open, every cycle with `wen`=1 is one sample. The window closes on the falling edge of `wen`, which increments `sweep_count`. When `sweep_count` reaches the latched `n_avg`, drain the pipeline and go to DONE.
  - DONE: `done`=1. On `arm`, go to ARMED with `done`=0 and `sweep_count`=0.
- `arm` in any state re-latches `n_avg`, clears `sweep_count`/`done`, goes to ARMED, and discards in-flight pipeline writes.
- `start` in IDLE or DONE is ignored. `start` in ACCUM while a window is open is ignored.
- `wen` outside an open window is ignored.
- Two-stage read-modify-write:
  - S0: register `address`/`din`, issue RAM read.
  - S1: sum = (sweep 0 ? 0 : RAM) + sign-extended `din`; write sum to RAM at the registered address.
- No hazard exists because addresses within a sweep are distinct. The pipeline fully drains between sweeps, since `start` is at least 1 cycle after `wen` falls.
- Arithmetic: `din` is sign-extended to ACC_WIDTH. The sum is modulo 2^ACC_WIDTH unless saturation is compiled in.
- The read port is independent. During ACCUM its value is valid RAM content but a partial sum.

## Timing
- Sample on `wen` at cycle t → RAM write at t+2 → visible on `rd_data` for a read issued at t+3 or later.
- Last sample of the final sweep at cycle t → `done`=1 and `busy`=0 from cycle t+3.
- `sweep_count` increments the cycle after `wen` falls.
- `rd_data` is registered: `rd_addr` at t → data at t+1.
- `arm` and `start` in the same cycle: `arm` wins, the state becomes ARMED, and that `start` is not accepted.
- `resetn` low mid-sweep: immediate IDLE, pipeline writes cancelled.

## Configuration
- `SWEEP_AVERAGER_SAT_EN` defined: on signed overflow the sum clamps to +2^(ACC_WIDTH-1)−1 or −2^(ACC_WIDTH-1).
- `SWEEP_AVERAGER_SAT_EN` undefined: the sum wraps modulo 2^ACC_WIDTH.

## Test plan
All scenarios use BRAM_WIDTH=4, DATA_WIDTH=14, ACC_WIDTH=16.
- Basic: `arm` with `n_avg`=1, then `start`, then 16 samples `din`=address. Required: `done` 3 cycles after the last sample, and `rd_data`[k]=k for k=0..15.
- Averaging: `n_avg`=4 with constant `din`=−3. Required: every address reads −12, `sweep_count`=4, and the first sweep overwrites the stale RAM content 0x7777.
- Ignored start: a `start` pulse in IDLE, and a second `start` mid-window. Required: no writes and no extra sweep, so after 2 sweeps with `n_avg`=2 each address equals 2·`din`.
- Re-arm mid-run: `arm` with `n_avg`=3 after 1.5 sweeps, then 3 clean sweeps of `din`=5. Required: all addresses read 15, and `done` is asserted exactly once.
- Reset: `resetn` low for 1 cycle mid-sweep. Required: `busy`=0, `done`=0, `sweep_count`=0 in the next cycle, and no further RAM writes.
- Overflow: `n_avg`=8, `din`=8191, ACC_WIDTH=16. Required: 32767 with `SWEEP_AVERAGER_SAT_EN` defined, and 65528 mod 2^16 reinterpreted as signed (−8) without it.
